// File: rtl/re_link_retimer.sv
// ============================================================================
// Module   : re_link_retimer
// Brief    : Per-link elastic token buffer in front of one retiming-unit link.
//            Forward tokens {a,r,c,d} are queued in a FIFO, a registered nack
//            is raised from occupancy/framing, and an acquire/release FSM keeps
//            a new stream out until the previous one has drained.
//            Optional feature macro: RE_LINK_RETIMER_STATS_EN (adds O_Words
//            pop counter and O_Peak occupancy high-water mark).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module re_link_retimer #(
  parameter int WIDTH_DATA  = 32,
  parameter int DEPTH_FIFO  = 16,
  parameter int WIDTH_DEPTH = $clog2(DEPTH_FIFO) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_FTk_v,
  input  logic                   I_FTk_a,
  input  logic                   I_FTk_r,
  input  logic                   I_FTk_c,
  input  logic [WIDTH_DATA-1:0]  I_FTk_d,
  output logic                   O_BTk_n,
  output logic                   O_BTk_t,
  output logic                   O_FTk_v,
  output logic                   O_FTk_a,
  output logic                   O_FTk_r,
  output logic                   O_FTk_c,
  output logic [WIDTH_DATA-1:0]  O_FTk_d,
  input  logic                   I_BTk_n,
  input  logic                   I_BTk_t,
`ifdef RE_LINK_RETIMER_STATS_EN
  output logic [31:0]            O_Words,
  output logic [WIDTH_DEPTH-1:0] O_Peak,
`endif
  output logic                   O_Err
);

  localparam int c_ptr_w   = $clog2(DEPTH_FIFO);
  localparam int c_entry_w = WIDTH_DATA + 3;
  localparam logic [WIDTH_DEPTH-1:0] c_full    = WIDTH_DEPTH'(DEPTH_FIFO);
  localparam logic [WIDTH_DEPTH-1:0] c_thresh  = WIDTH_DEPTH'(DEPTH_FIFO - 1);
  localparam logic [WIDTH_DEPTH-1:0] c_cnt_one = WIDTH_DEPTH'(1);
  localparam logic [c_ptr_w-1:0]     c_ptr_one = c_ptr_w'(1);

  // Framing state: IDLE between streams, ACTIVE inside one, DRAIN after release
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [c_entry_w-1:0]    r_mem [DEPTH_FIFO];
  logic [c_ptr_w-1:0]      r_wr_ptr;
  logic [c_ptr_w-1:0]      r_rd_ptr;
  logic [WIDTH_DEPTH-1:0]  r_count;
  logic [WIDTH_DEPTH-1:0]  w_count_next;
  logic                    r_btk_n;
  logic                    r_btk_t;
  logic                    r_err;
  logic                    w_nonempty;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_ovf;
  logic                    w_flush;
  logic [c_entry_w-1:0]    w_head;
  logic [c_entry_w-1:0]    w_wdata;

  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty & ~I_BTk_n;
  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign w_push     = I_FTk_v & ((r_count != c_full) | w_pop);
  assign w_ovf      = I_FTk_v & (r_count == c_full) & ~w_pop;
  // Downstream termination only aborts a stream that is actually in flight
  assign w_flush    = I_BTk_t & (r_state != ST_IDLE);
  assign w_head     = w_nonempty ? r_mem[r_rd_ptr] : '0;
  assign w_wdata    = {I_FTk_a, I_FTk_r, I_FTk_c, I_FTk_d};

  // Next occupancy and next framing state from accepted pushes/pops
  always_comb begin
    w_count_next = r_count;
    w_state_next = r_state;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_cnt_one;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - c_cnt_one;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_push && I_FTk_a) begin
          w_state_next = I_FTk_r ? ST_DRAIN : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_push && I_FTk_r) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Release word leaving with nothing behind it closes the stream
        if (w_pop && w_head[WIDTH_DATA+1] && (w_count_next == '0)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_flush) begin
      w_count_next = '0;
      w_state_next = ST_IDLE;
    end
  end

  // Control registers: occupancy, pointers, state, nack/term/error flags
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_state  <= ST_IDLE;
      r_btk_n  <= 1'b0;
      r_btk_t  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_state <= w_state_next;
      // One entry of slack absorbs the word already launched when nack rises
      r_btk_n <= (w_count_next >= c_thresh) | (w_state_next == ST_DRAIN);
      r_btk_t <= I_BTk_t;
      if (w_ovf) begin
        r_err <= 1'b1;
      end
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  // Token storage; contents are don't-care until counted in by r_count
  always_ff @(posedge clock) begin
    if (w_push && !w_flush) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

`ifdef RE_LINK_RETIMER_STATS_EN
  logic [31:0]            r_words;
  logic [WIDTH_DEPTH-1:0] r_peak;

  // Pop counter (free-running wrap) and occupancy high-water mark
  always_ff @(posedge clock) begin
    if (reset) begin
      r_words <= '0;
      r_peak  <= '0;
    end else begin
      if (w_pop) r_words <= r_words + 32'd1;
      if (w_count_next > r_peak) r_peak <= w_count_next;
    end
  end

  assign O_Words = r_words;
  assign O_Peak  = r_peak;
`endif

  assign O_FTk_v = w_pop;
  assign O_FTk_a = w_head[WIDTH_DATA+2];
  assign O_FTk_r = w_head[WIDTH_DATA+1];
  assign O_FTk_c = w_head[WIDTH_DATA];
  assign O_FTk_d = w_head[WIDTH_DATA-1:0];
  assign O_BTk_n = r_btk_n;
  assign O_BTk_t = r_btk_t;
  assign O_Err   = r_err;

endmodule

`default_nettype wire
